fpga_status_led_ctrl: RTL and testbench
=======================================

// Module: fpga_status_led_ctrl
// PURPOSE
//  Parametrised board-status LED controller for the FPGA top wrappers; supersedes the fixed
//  clock-count blink LED. Drives NUM_LED LEDs, each with a runtime mode (off/on/blink/pulse)
//  and period in ms, from one shared ms prescaler. Sticky exit override shows pass/fail on all LEDs.
// PARAMETERS
//  NUM_LED        4      number of LED channels (1..16)
//  TICK_DIV       20000  clk_i cycles per ms tick (20 MHz clk_gen -> 1 ms)
//  CNT_W          10     width of per-channel period/ms counters
//  DEF_PERIOD_MS  500    channel-0 blink period after reset (heartbeat)
//  FAIL_PERIOD_MS 100    override blink half-period when exit value != 0
// PORTS
//  clk_i          in   1                  system clock (clk_gen)
//  rst_i          in   1                  async reset, active-high
//  cfg_we_i       in   1                  config write strobe, one cycle
//  cfg_idx_i      in   $clog2(NUM_LED)+1  target channel (wide enough to address out of range)
//  cfg_mode_i     in   2                  led_mode_e: 00 OFF, 01 ON, 10 BLINK, 11 PULSE
//  cfg_period_i   in   CNT_W              blink half-period / pulse length in ms; 0 treated as 1
//  event_i        in   NUM_LED            synchronous per-channel pulse triggers
//  exit_valid_i   in   1                  program-exit valid (synchronous level)
//  exit_value_i   in   32                 program exit value
//  led_o          out  NUM_LED            registered LED drive, 1 = lit
//  tick_o         out  1                  1-cycle ms tick strobe
//  override_o     out  1                  1 while exit override is active
// BEHAVIOUR
//  Interface: one clock clk_i; reset rst_i is asynchronous and active-high.
//  Reset: led_o=0, tick_o=0, override_o=0, prescaler=0; ch0 mode BLINK, period DEF_PERIOD_MS;
//   other channels OFF, period 1; all channel counters/states 0; event and exit edge registers 0.
//  Prescaler: counts 0..TICK_DIV-1, wraps; tick_o=1 the cycle after the count is TICK_DIV-1.
//  Cfg write: applied at next edge; clears that channel's cnt and state to 0. idx>=NUM_LED ignored.
//   A write and an event on the same channel in the same cycle: the write wins, the event is dropped.
//  OFF: state=0. ON: state=1 on the next edge after entering ON.
//  BLINK: on each tick, cnt++; when cnt==P-1 (P=max(period,1)) cnt<=0 and state toggles.
//   Duty 50 %, full period 2*P ms. First toggle P ticks after the cfg write.
//  PULSE: rising edge of event_i[n] (vs registered copy) -> state<=1, cnt<=0 (retrigger restarts).
//   While state=1, each tick cnt++; at cnt==P-1 state<=0, cnt<=0. Event while high = retrigger.
//   Event_i in non-PULSE modes is ignored; its edge register still updates.
//  Exit override: rising edge of exit_valid_i latches pass=(exit_value_i==0) and sets override
//   (sticky until rst_i; later edges ignored). Pass: all led_o=1. Fail: all LEDs toggle together
//   every FAIL_PERIOD_MS ticks on a dedicated counter, starting lit. Channels keep running and
//   accepting cfg writes underneath; their states become visible again only after reset.
//  led_o: registered, equal to the channel/override value computed at the previous edge (1-cycle lag).
//  Counter wrap: cnt never exceeds P-1; lowering period below cnt via cfg write is safe (cfg clears cnt).
//  Reset mid-operation: all state returns to reset values asynchronously; no tick is produced.
// STRUCTURE
//  Package fpga_status_led_pkg: typedef enum logic [1:0] led_mode_e {LED_OFF,LED_ON,LED_BLINK,
//   LED_PULSE}; localparams for mode encodings and default-channel config.
//  Sub-module fpga_led_channel (one per LED, generate loop): mode/period regs, cnt, state,
//   event edge detect; inputs tick, cfg_we (already index-decoded), event; output state.
//  Top: prescaler, index decode, exit edge detect + override FSM (IDLE -> PASS | FAIL), output regs.
// TESTING (TICK_DIV=4, DEF_PERIOD_MS=3, FAIL_PERIOD_MS=2, NUM_LED=4)
//  1. Release reset -> tick_o every 4 cycles; led_o[0] toggles every 12 cycles, led_o[3:1]=0.
//  2. cfg ch2 ON -> led_o[2]=1 two edges after write; cfg idx=5 -> no channel changes.
//  3. cfg ch1 PULSE period 2, event_i[1] pulse -> led_o[1] high ~8 cycles; retrigger at 4 -> ~12.
//  4. cfg ch1 same cycle as event_i[1] rise -> event dropped, led_o[1] stays 0.
//  5. exit_valid_i=1, exit_value_i=0 -> override_o=1, led_o=4'hF held; later cfg writes invisible.
//  6. exit_value_i=32'h1 -> led_o alternates F/0 every 8 cycles; assert rst_i mid-blink -> all 0 at once.

Source files
------------

// File: rtl/fpga_status_led_pkg.sv
// Shared types and reset defaults for the board-status LED controller.
package fpga_status_led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'b00,
        LED_ON    = 2'b01,
        LED_BLINK = 2'b10,
        LED_PULSE = 2'b11
    } led_mode_e;

    typedef enum logic [1:0] {
        OVR_IDLE = 2'b00,
        OVR_PASS = 2'b01,
        OVR_FAIL = 2'b10
    } ovr_state_e;

    localparam int        LED_MODE_W     = 2;
    localparam led_mode_e CH0_RST_MODE   = LED_BLINK;
    localparam led_mode_e CHN_RST_MODE   = LED_OFF;
    localparam int        CHN_RST_PERIOD = 1;

endpackage

// File: rtl/fpga_led_channel.sv
// One LED channel: runtime mode/period registers, ms counter, and event edge detect.
module fpga_led_channel
    import fpga_status_led_pkg::*;
#(
    parameter int        CNT_W      = 10,
    parameter led_mode_e RST_MODE   = LED_OFF,
    parameter int        RST_PERIOD = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  tick_i,
    input  logic                  cfg_we_i,
    input  logic [LED_MODE_W-1:0] cfg_mode_i,
    input  logic [CNT_W-1:0]      cfg_period_i,
    input  logic                  event_i,
    output logic                  state_o
);

    led_mode_e        mode_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] last_cnt;
    logic             evt_q;
    logic             evt_rise;

    // A zero period behaves as one, so the terminal count is never below zero.
    assign last_cnt = (period_q == '0) ? '0 : period_q - CNT_W'(1);
    assign evt_rise = event_i & ~evt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q   <= RST_MODE;
            period_q <= CNT_W'(RST_PERIOD);
            cnt_q    <= '0;
            state_o  <= 1'b0;
            evt_q    <= 1'b0;
        end else begin
            evt_q <= event_i;
            if (cfg_we_i) begin
                mode_q   <= led_mode_e'(cfg_mode_i);
                period_q <= cfg_period_i;
                cnt_q    <= '0;
                state_o  <= 1'b0;
            end else begin
                unique case (mode_q)
                    LED_OFF: begin
                        state_o <= 1'b0;
                        cnt_q   <= '0;
                    end
                    LED_ON: begin
                        state_o <= 1'b1;
                        cnt_q   <= '0;
                    end
                    LED_BLINK: begin
                        if (tick_i) begin
                            if (cnt_q == last_cnt) begin
                                cnt_q   <= '0;
                                state_o <= ~state_o;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    LED_PULSE: begin
                        // A new edge restarts the pulse even if one is already running.
                        if (evt_rise) begin
                            state_o <= 1'b1;
                            cnt_q   <= '0;
                        end else if (state_o && tick_i) begin
                            if (cnt_q == last_cnt) begin
                                state_o <= 1'b0;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/fpga_status_led_ctrl.sv
// Board-status LED controller: shared ms prescaler, NUM_LED channels and a sticky
// program-exit override that shows pass (all lit) or fail (all blinking).
module fpga_status_led_ctrl
    import fpga_status_led_pkg::*;
#(
    parameter int NUM_LED        = 4,
    parameter int TICK_DIV       = 20000,
    parameter int CNT_W          = 10,
    parameter int DEF_PERIOD_MS  = 500,
    parameter int FAIL_PERIOD_MS = 100
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cfg_we_i,
    input  logic [$clog2(NUM_LED):0]  cfg_idx_i,
    input  logic [LED_MODE_W-1:0]     cfg_mode_i,
    input  logic [CNT_W-1:0]          cfg_period_i,
    input  logic [NUM_LED-1:0]        event_i,
    input  logic                      exit_valid_i,
    input  logic [31:0]               exit_value_i,
    output logic [NUM_LED-1:0]        led_o,
    output logic                      tick_o,
    output logic                      override_o
);

    localparam int IDX_W  = $clog2(NUM_LED) + 1;
    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FAIL_W = $clog2(FAIL_PERIOD_MS + 1);

    logic [PRE_W-1:0]   pre_cnt;
    logic               pre_wrap;
    logic [NUM_LED-1:0] ch_we;
    logic [NUM_LED-1:0] ch_state;
    ovr_state_e         ovr_q;
    ovr_state_e         ovr_nxt;
    logic               exit_q;
    logic               exit_rise;
    logic [FAIL_W-1:0]  fail_cnt;
    logic               fail_led;
    logic [NUM_LED-1:0] led_nxt;

    assign pre_wrap = (pre_cnt == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_cnt <= '0;
            tick_o  <= 1'b0;
        end else begin
            tick_o  <= pre_wrap;
            pre_cnt <= pre_wrap ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    for (genvar n = 0; n < NUM_LED; n++) begin : g_ch
        assign ch_we[n] = cfg_we_i && (cfg_idx_i == IDX_W'(n));

        fpga_led_channel #(
            .CNT_W      (CNT_W),
            .RST_MODE   ((n == 0) ? CH0_RST_MODE : CHN_RST_MODE),
            .RST_PERIOD ((n == 0) ? DEF_PERIOD_MS : CHN_RST_PERIOD)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .tick_i       (tick_o),
            .cfg_we_i     (ch_we[n]),
            .cfg_mode_i   (cfg_mode_i),
            .cfg_period_i (cfg_period_i),
            .event_i      (event_i[n]),
            .state_o      (ch_state[n])
        );
    end

    assign exit_rise = exit_valid_i & ~exit_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovr_q  <= OVR_IDLE;
            exit_q <= 1'b0;
        end else begin
            ovr_q  <= ovr_nxt;
            exit_q <= exit_valid_i;
        end
    end

    // Override is sticky: once PASS or FAIL is reached only reset leaves it.
    always_comb begin
        ovr_nxt = ovr_q;
        unique case (ovr_q)
            OVR_IDLE: begin
                if (exit_rise) begin
                    ovr_nxt = (exit_value_i == 32'd0) ? OVR_PASS : OVR_FAIL;
                end
            end
            OVR_PASS: ovr_nxt = OVR_PASS;
            OVR_FAIL: ovr_nxt = OVR_FAIL;
            default:  ovr_nxt = OVR_IDLE;
        endcase
    end

    // Held at "lit, count 0" until FAIL is entered so the fail blink starts lit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fail_cnt <= '0;
            fail_led <= 1'b0;
        end else if (ovr_q != OVR_FAIL) begin
            fail_cnt <= '0;
            fail_led <= 1'b1;
        end else if (tick_o) begin
            if (fail_cnt == FAIL_W'(FAIL_PERIOD_MS - 1)) begin
                fail_cnt <= '0;
                fail_led <= ~fail_led;
            end else begin
                fail_cnt <= fail_cnt + FAIL_W'(1);
            end
        end
    end

    always_comb begin
        led_nxt = ch_state;
        unique case (ovr_q)
            OVR_PASS: led_nxt = '1;
            OVR_FAIL: led_nxt = {NUM_LED{fail_led}};
            default:  led_nxt = ch_state;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led_o <= '0;
        end else begin
            led_o <= led_nxt;
        end
    end

    assign override_o = (ovr_q != OVR_IDLE);

endmodule

// File: tb/tb_fpga_status_led_ctrl.sv
// Directed bench for fpga_status_led_ctrl with a 4-cycle ms tick.
module tb_fpga_status_led_ctrl;
    import fpga_status_led_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [1:0]  cfg_mode = '0;
    logic [9:0]  cfg_period = '0;
    logic [3:0]  event_v = '0;
    logic        exit_valid = 1'b0;
    logic [31:0] exit_value = '0;
    logic [3:0]  led;
    logic        tick;
    logic        ovr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpga_status_led_ctrl #(
        .NUM_LED        (4),
        .TICK_DIV       (4),
        .CNT_W          (10),
        .DEF_PERIOD_MS  (3),
        .FAIL_PERIOD_MS (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_we_i     (cfg_we),
        .cfg_idx_i    (cfg_idx),
        .cfg_mode_i   (cfg_mode),
        .cfg_period_i (cfg_period),
        .event_i      (event_v),
        .exit_valid_i (exit_valid),
        .exit_value_i (exit_value),
        .led_o        (led),
        .tick_o       (tick),
        .override_o   (ovr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input int idx, input logic [1:0] mode, input int per);
        cfg_we     = 1'b1;
        cfg_idx    = 3'(idx);
        cfg_mode   = mode;
        cfg_period = 10'(per);
        step(1);
        cfg_we     = 1'b0;
    endtask

    // Returns just after the edge at which tick_o rises.
    task automatic wait_tick();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step(1);
            if (tick) seen = 1'b1;
        end
        chk("tick_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        step(2);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_ovr", 32'(ovr), 32'h0);

        // Heartbeat: tick every 4 cycles, ch0 toggles every 12.
        rst = 1'b0;
        step(3);  chk("tick_pre", 32'(tick), 32'h0);
        step(1);  chk("tick_first", 32'(tick), 32'h1);
        step(1);  chk("tick_one_cycle", 32'(tick), 32'h0);
        step(3);  chk("tick_second", 32'(tick), 32'h1);
        step(5);  chk("hb_before", 32'(led), 32'h0);
        step(1);  chk("hb_on", 32'(led), 32'h1);
        step(11); chk("hb_hold", 32'(led), 32'h1);
        step(1);  chk("hb_off", 32'(led), 32'h0);

        // ON mode and out-of-range index.
        cfg(2, LED_ON, 1);
        chk("on_lag0", 32'(led[2]), 32'h0);
        step(1); chk("on_lag1", 32'(led[2]), 32'h0);
        step(1); chk("on_lit", 32'(led[2]), 32'h1);
        cfg(5, LED_ON, 1);
        step(3);
        chk("idx5_ch1", 32'(led[1]), 32'h0);
        chk("idx5_ch3", 32'(led[3]), 32'h0);
        chk("idx5_ch2", 32'(led[2]), 32'h1);

        // Pulse: 8 cycles high when triggered right after a tick.
        cfg(1, LED_PULSE, 2);
        wait_tick();
        event_v[1] = 1'b1;
        step(1); event_v[1] = 1'b0;
        chk("pulse_lag", 32'(led[1]), 32'h0);
        step(1); chk("pulse_on", 32'(led[1]), 32'h1);
        step(7); chk("pulse_hold", 32'(led[1]), 32'h1);
        step(1); chk("pulse_off", 32'(led[1]), 32'h0);

        // Retrigger four cycles in stretches the pulse to 12 cycles.
        wait_tick();
        event_v[1] = 1'b1;
        step(1); event_v[1] = 1'b0;
        step(3); event_v[1] = 1'b1;
        step(1); event_v[1] = 1'b0;
        step(8); chk("retrig_hold", 32'(led[1]), 32'h1);
        step(1); chk("retrig_off", 32'(led[1]), 32'h0);

        // Write and event rise in the same cycle: event dropped.
        event_v[1] = 1'b1;
        cfg(1, LED_PULSE, 2);
        step(1); event_v[1] = 1'b0;
        step(2);  chk("wr_wins_a", 32'(led[1]), 32'h0);
        step(10); chk("wr_wins_b", 32'(led[1]), 32'h0);

        // Pass override: all lit, sticky, hides later config.
        chk("ovr_idle", 32'(ovr), 32'h0);
        exit_value = 32'h0;
        exit_valid = 1'b1;
        step(1); chk("pass_ovr", 32'(ovr), 32'h1);
        step(1); chk("pass_led", 32'(led), 32'hF);
        cfg(2, LED_OFF, 1);
        step(3); chk("pass_hide_cfg", 32'(led), 32'hF);
        exit_valid = 1'b0;
        step(1);
        exit_value = 32'h1;
        exit_valid = 1'b1;
        step(12);
        chk("pass_sticky_led", 32'(led), 32'hF);
        chk("pass_sticky_ovr", 32'(ovr), 32'h1);

        // Async reset clears the override immediately.
        exit_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_led", 32'(led), 32'h0);
        chk("arst_ovr", 32'(ovr), 32'h0);

        // Fail override: all LEDs alternate every 8 cycles, starting lit.
        step(1);
        rst = 1'b0;
        exit_value = 32'h1;
        exit_valid = 1'b1;
        step(1); chk("fail_ovr", 32'(ovr), 32'h1);
        step(1); chk("fail_lit", 32'(led), 32'hF);
        step(7); chk("fail_lit_end", 32'(led), 32'hF);
        step(1); chk("fail_dark", 32'(led), 32'h0);
        step(7); chk("fail_dark_end", 32'(led), 32'h0);
        step(1); chk("fail_relit", 32'(led), 32'hF);

        rst = 1'b1;
        #1;
        chk("mid_rst_led", 32'(led), 32'h0);
        chk("mid_rst_ovr", 32'(ovr), 32'h0);
        chk("mid_rst_tick", 32'(tick), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
